// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter: FSM state encoding and the
// pointer-width helper used to size requester indices.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // A single requester still needs a 1-bit index, so never return zero.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// after 'start', wrapping past NUM_REQ-1 back to 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   start,
  output logic [PTR_W-1:0]   grant,
  output logic               any
);

  logic [PTR_W-1:0] low_idx;
  logic [PTR_W-1:0] high_idx;
  logic             high_found;

  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    low_idx    = '0;
    high_idx   = '0;
    high_found = 1'b0;
    any        = 1'b0;
    // Scan downwards so the lowest matching index is the one that sticks.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any     = 1'b1;
        low_idx = PTR_W'(i);
        if (i >= int'(start)) begin
          high_found = 1'b1;
          high_idx   = PTR_W'(i);
        end
      end
    end
    grant = high_found ? high_idx : low_idx;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Define FIFO_ARB_BURST_EN to let an owner keep the grant for BURST_LEN beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int FW        = 8,
  parameter  int BURST_LEN = 4,
  parameter  int CNT_W     = 16,
  localparam int PTR_W     = ptr_w(NUM_REQ)
) (
  input  logic                  w_clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*FW-1:0] req_data,
  output logic [NUM_REQ-1:0]    ack,
  input  logic                  fifo_full,
  input  logic                  fifo_overflow,
  output logic                  fifo_wr,
  output logic [FW-1:0]         fifo_wdata,
  output logic [PTR_W-1:0]      owner,
  output logic                  busy,
  output logic [CNT_W-1:0]      wr_count,
  output logic                  ovf_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1) begin : g_param_err
    $error("fifo_wr_arbiter: unsupported NUM_REQ or BURST_LEN");
  end

  state_t           state;
  logic [PTR_W-1:0] last;
  logic [PTR_W-1:0] pick_start;
  logic [PTR_W-1:0] pick;
  logic             pick_any;
  logic             fire;
  logic             rotate;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // From IDLE the search resumes after the last writer; inside a grant it
  // resumes after the current owner.
  assign pick_start = (state == IDLE) ? next_idx(last) : next_idx(owner);

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req),
    .start (pick_start),
    .grant (pick),
    .any   (pick_any)
  );

  // Write strobe, ack and data are combinational from the registered state so
  // a full FIFO blocks the write in the very cycle it is seen.
  assign fire       = (state == GRANT) && req[owner] && !fifo_full;
  assign fifo_wr    = fire;
  assign ack        = fire ? (NUM_REQ'(1) << owner) : '0;
  assign fifo_wdata = req_data[int'(owner)*FW +: FW];
  assign busy       = (state == GRANT);

`ifdef FIFO_ARB_BURST_EN
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  logic [BEAT_W-1:0] beat;

  assign rotate = (beat == BEAT_W'(BURST_LEN - 1));

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
    end else if (state == GRANT) begin
      if (fire) begin
        beat <= rotate ? '0 : beat + BEAT_W'(1);
      end else if (!req[owner]) begin
        beat <= '0;
      end
    end
  end
`else
  assign rotate = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      last     <= PTR_W'(NUM_REQ - 1);
      wr_count <= '0;
      ovf_err  <= 1'b0;
    end else begin
      if (fifo_overflow) ovf_err <= 1'b1;
      if (fire) wr_count <= wr_count + CNT_W'(1);

      case (state)
        IDLE: begin
          if (pick_any) begin
            owner <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (fire) begin
            last <= owner;
            if (rotate) owner <= pick;
          end else if (!req[owner]) begin
            if (pick_any) owner <= pick;
            else          state <= IDLE;
          end
          // req[owner] with fifo_full: stall, hold everything.
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (default or
// FIFO_ARB_BURST_EN build) with hand-written reset and overflow sequences.
module tb_fifo_wr_arbiter;

  logic        w_clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        fifo_full;
  logic        fifo_overflow;
  logic        fifo_wr;
  logic [7:0]  fifo_wdata;
  logic [1:0]  owner;
  logic        busy;
  logic [15:0] wr_count;
  logic        ovf_err;

  fifo_wr_arbiter #(
    .NUM_REQ(4), .FW(8), .BURST_LEN(4), .CNT_W(16)
  ) dut (
    .w_clk         (w_clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .fifo_full     (fifo_full),
    .fifo_overflow (fifo_overflow),
    .fifo_wr       (fifo_wr),
    .fifo_wdata    (fifo_wdata),
    .owner         (owner),
    .busy          (busy),
    .wr_count      (wr_count),
    .ovf_err       (ovf_err)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic [3:0] ack;
    logic       wr;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t       tbl[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] dval [4] = '{8'hC0, 8'hB1, 8'hA5, 8'hD3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic f, input logic [3:0] a,
                              input logic w, input logic [1:0] o, input logic b);
    vec_t v;
    v.req = r; v.full = f; v.ack = a; v.wr = w; v.owner = o; v.busy = b;
    return v;
  endfunction

  // Drive row i just after a rising edge, compare mid-cycle, advance one clock.
  task automatic apply_tbl(input string tag);
    foreach (tbl[i]) begin
      req       = tbl[i].req;
      fifo_full = tbl[i].full;
      @(negedge w_clk);
      check($sformatf("%s[%0d].ack", tag, i), ack, tbl[i].ack);
      check($sformatf("%s[%0d].wr", tag, i), fifo_wr, tbl[i].wr);
      check($sformatf("%s[%0d].owner", tag, i), owner, tbl[i].owner);
      check($sformatf("%s[%0d].busy", tag, i), busy, tbl[i].busy);
      if (tbl[i].busy) check($sformatf("%s[%0d].wdata", tag, i), fifo_wdata, dval[tbl[i].owner]);
      @(posedge w_clk);
      #1;
    end
    tbl.delete();
  endtask

  initial begin
    rst_n         = 1'b0;
    req           = '0;
    fifo_full     = 1'b0;
    fifo_overflow = 1'b0;
    req_data      = {dval[3], dval[2], dval[1], dval[0]};

    repeat (2) @(posedge w_clk);
    #1;
    check("rst.wr", fifo_wr, 1'b0);
    check("rst.ack", ack, 4'b0000);
    check("rst.busy", busy, 1'b0);
    check("rst.owner", owner, 2'd0);
    check("rst.wr_count", wr_count, 16'd0);
    check("rst.ovf_err", ovf_err, 1'b0);
    @(negedge w_clk);
    rst_n = 1'b1;
    @(posedge w_clk);
    #1;

    // Single requester 2, then a 3-cycle full stall on requester 1.
    tbl.push_back(mk(4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0));
    repeat (3) tbl.push_back(mk(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0));
    tbl.push_back(mk(4'b0010, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0));
    repeat (3) tbl.push_back(mk(4'b0010, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1));
    tbl.push_back(mk(4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b1));
    apply_tbl("single_stall");
    check("single_stall.wr_count", wr_count, 16'd4);
    check("single_stall.idle", busy, 1'b0);

    // Asynchronous reset while a beat is about to be accepted.
    req = 4'b0100;
    @(posedge w_clk);
    #1;
    check("pre_rst.wr", fifo_wr, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst.wr", fifo_wr, 1'b0);
    check("mid_rst.ack", ack, 4'b0000);
    check("mid_rst.busy", busy, 1'b0);
    check("mid_rst.owner", owner, 2'd0);
    check("mid_rst.wr_count", wr_count, 16'd0);
    req = 4'b0000;
    @(negedge w_clk);
    rst_n = 1'b1;
    @(posedge w_clk);
    #1;
    check("post_rst.wr_count", wr_count, 16'd0);

    // All four requesting: grant order after reset starts at requester 0.
    tbl.push_back(mk(4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0));
    for (int k = 0; k < 8; k++) begin
`ifdef FIFO_ARB_BURST_EN
      tbl.push_back(mk(4'b1111, 1'b0, 4'b0001 << (k / 4), 1'b1, 2'(k / 4), 1'b1));
`else
      tbl.push_back(mk(4'b1111, 1'b0, 4'b0001 << (k % 4), 1'b1, 2'(k % 4), 1'b1));
`endif
    end
`ifdef FIFO_ARB_BURST_EN
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1));
`else
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1));
`endif
    apply_tbl("all_req");
    check("all_req.wr_count", wr_count, 16'd8);

    // Two requesters: per-beat alternation, or 4-beat bursts with the option.
`ifdef FIFO_ARB_BURST_EN
    tbl.push_back(mk(4'b0011, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0));
    for (int k = 0; k < 12; k++)
      tbl.push_back(mk(4'b0011, 1'b0, 4'b0001 << ((k / 4) % 2), 1'b1, 2'((k / 4) % 2), 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b1));
`else
    tbl.push_back(mk(4'b0011, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0));
    for (int k = 0; k < 12; k++)
      tbl.push_back(mk(4'b0011, 1'b0, 4'b0001 << (k % 2), 1'b1, 2'(k % 2), 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1));
`endif
    apply_tbl("two_req");
    check("two_req.wr_count", wr_count, 16'd20);

    // Sticky overflow flag, cleared only by reset.
    check("ovf.before", ovf_err, 1'b0);
    fifo_overflow = 1'b1;
    @(posedge w_clk);
    #1 fifo_overflow = 1'b0;
    check("ovf.set", ovf_err, 1'b1);
    repeat (3) @(posedge w_clk);
    #1;
    check("ovf.sticky", ovf_err, 1'b1);
    rst_n = 1'b0;
    #1;
    check("ovf.cleared", ovf_err, 1'b0);
    @(negedge w_clk);
    rst_n = 1'b1;
    @(posedge w_clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
